// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one op at a time on an 8-bit memory bus, tagged result broadcast.
// Define LSU_MISALIGN_CHECK_EN to add the misalign output and fault misaligned accesses without bus activity.

module load_store_unit #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        op,
  input  logic [ADDR_W-1:0] value1,
  input  logic [31:0]       value2,
  input  logic [ADDR_W-1:0] imm,
  input  logic [2:0]        des,
  output logic              lsu_busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic [31:0]       result_data,
  output logic [2:0]        result_des
);

  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOAD_TAIL, S_DONE} state_e;

  state_e            state_q;
  logic [4:0]        op_q;
  logic [2:0]        des_q;
  logic [3:0][7:0]   st_data_q;
  logic [3:0][7:0]   ld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        k_q;
  logic [31:0]       result_data_q;
  logic [2:0]        result_des_q;

  function automatic logic [1:0] last_idx(input logic [4:0] o);
    case (o)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [4:0] o);
    return (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;

  function automatic logic is_misaligned(input logic [4:0] o, input logic [1:0] a_lo);
    return ((o == OP_LH || o == OP_LHU || o == OP_SH) && a_lo[0]) ||
           ((o == OP_LW || o == OP_SW) && (a_lo != 2'b00));
  endfunction
`endif

  logic [ADDR_W-1:0] eff_addr;
  logic              accept_ok;
  logic              store_q;
  logic              byte_cycle;
  logic              io_stall;
  logic [1:0]        last_k;
  logic [1:0]        prev_k;
  logic [3:0][7:0]   load_word;
  logic [31:0]       load_ext;

  assign eff_addr   = value1 + imm;
  assign accept_ok  = (state_q == S_IDLE || state_q == S_DONE) && op >= OP_LB && op <= OP_SW;
  assign store_q    = is_store_op(op_q);
  assign byte_cycle = (state_q == S_ISSUE);
  assign last_k     = last_idx(op_q);
  assign prev_k     = k_q - 2'd1;
  // IO stores back off while the write buffer is full; loads never stall.
  assign io_stall   = store_q && (addr_q[17:16] == IO_MASK_HI) && io_buffer_full;

  // The final byte comes straight off mem_din in LOAD_TAIL, merged with the bytes already held.
  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    load_word         = ld_q;
    load_word[last_k] = mem_din;
    case (op_q)
      OP_LB:   load_ext = {{24{load_word[0][7]}}, load_word[0]};
      OP_LH:   load_ext = {{16{load_word[1][7]}}, load_word[1], load_word[0]};
      OP_LBU:  load_ext = {24'd0, load_word[0]};
      OP_LHU:  load_ext = {16'd0, load_word[1], load_word[0]};
      default: load_ext = load_word;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: data registers are reset too, so outputs and the held result are clean after reset.
      state_q       <= S_IDLE;
      op_q          <= '0;
      des_q         <= '0;
      st_data_q     <= '0;
      ld_q          <= '0;
      addr_q        <= '0;
      k_q           <= '0;
      result_data_q <= '0;
      result_des_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      result_des_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
      unique case (state_q)
        S_ISSUE: begin
          if (k_q != 2'd0) ld_q[prev_k] <= mem_din;
          if (!io_stall) begin
            if (k_q == last_k) begin
              if (store_q) begin
                state_q       <= S_DONE;
                result_data_q <= '0;
                result_des_q  <= des_q;
              end else begin
                state_q <= S_LOAD_TAIL;
              end
            end else begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        S_LOAD_TAIL: begin
          ld_q[last_k]  <= mem_din;
          result_data_q <= load_ext;
          result_des_q  <= des_q;
          state_q       <= S_DONE;
        end
        default: begin
          if (accept_ok) begin
            op_q      <= op;
            des_q     <= des;
            st_data_q <= value2;
            addr_q    <= eff_addr;
            k_q       <= 2'd0;
`ifdef LSU_MISALIGN_CHECK_EN
            if (is_misaligned(op, eff_addr[1:0])) begin
              state_q       <= S_DONE;
              result_data_q <= '0;
              result_des_q  <= des;
              misalign_q    <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
`else
            state_q <= S_ISSUE;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held so an aborted store cannot finish its current byte.
  assign lsu_busy    = rst && (state_q == S_ISSUE || state_q == S_LOAD_TAIL);
  assign mem_wr      = rst && byte_cycle && store_q && !io_stall;
  assign mem_a       = (rst && byte_cycle && !io_stall) ? addr_q + {{(ADDR_W-2){1'b0}}, k_q} : '0;
  assign mem_dout    = (rst && byte_cycle && store_q) ? st_data_q[k_q] : '0;
  assign result_data = rst ? result_data_q : '0;
  assign result_des  = rst ? result_des_q : '0;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign    = rst && misalign_q;
`endif

endmodule
